// File: rtl/vtp_fail_log_pkg.sv
// vtp_fail_log_pkg: record layout and widths for the VTP translation-failure log.
package vtp_fail_log_pkg;
  localparam int VTP_FAIL_SEQ_W = 16;
  localparam int VTP_FAIL_DROP_W = 16;
  typedef struct packed {
    logic                      is_write;
    logic [VTP_FAIL_SEQ_W-1:0] seq;
    logic [57:0]               va_line;
  } t_vtp_fail_rec;
endpackage

// File: rtl/vtp_fail_log_fifo2w.sv
// vtp_fail_log_fifo2w: flop-array FIFO with two ordered write ports, one read port and an occupancy count.
module vtp_fail_log_fifo2w
  import vtp_fail_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we0,
  input  t_vtp_fail_rec    d0,
  input  logic             we1,
  input  t_vtp_fail_rec    d1,
  input  logic             pop,
  output t_vtp_fail_rec    head,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  t_vtp_fail_rec  mem [DEPTH];
  logic [AW-1:0]  wp, rp;
  logic           do_pop;
  assign do_pop = pop && count != '0;
  // Port 1 lands behind port 0 when both write, preserving event order.
  always_ff @(posedge clk) begin
    if (we0) mem[wp] <= d0;
    if (we1) mem[wp + AW'(we0)] <= d1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(we0) + AW'(we1);
      rp    <= rp + AW'(do_pop);
      count <= count + CNT_W'(we0) + CNT_W'(we1) - CNT_W'(do_pop);
    end
  end
  assign head = mem[rp];
endmodule

// File: rtl/vtp_fail_log.sv
// vtp_fail_log: ordered, lossless-until-full log of VTP read/write translation failures with sticky overflow.
module vtp_fail_log
  import vtp_fail_log_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_fail_valid,
  input  logic [63:0]                rd_fail_va,
  input  logic                       wr_fail_valid,
  input  logic [63:0]                wr_fail_va,
  input  logic                       pop,
  output logic                       rec_valid,
  output logic [63:0]                rec_va,
  output logic                       rec_is_write,
  output logic [VTP_FAIL_SEQ_W-1:0]  rec_seq,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [VTP_FAIL_DROP_W-1:0] drop_cnt
);
  logic [VTP_FAIL_SEQ_W-1:0] seq_ctr;
  logic [CNT_W:0]            space;
  logic                      acc_rd, acc_wr;
  logic [1:0]                n_drop;
  logic [VTP_FAIL_DROP_W:0]  drop_sum;
  t_vtp_fail_rec             rd_rec, wr_rec, head;
  logic                      unused_va_bits;
  assign unused_va_bits = ^{rd_fail_va[5:0], wr_fail_va[5:0]};
  // A pop in the same cycle frees a slot for the incoming events.
  assign space    = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(pop && rec_valid);
  assign acc_rd   = rd_fail_valid && space != '0;
  assign acc_wr   = wr_fail_valid && space >= (rd_fail_valid ? (CNT_W+1)'(2) : (CNT_W+1)'(1));
  assign n_drop   = 2'(rd_fail_valid && !acc_rd) + 2'(wr_fail_valid && !acc_wr);
  assign drop_sum = {1'b0, clear_overflow ? '0 : drop_cnt} + (VTP_FAIL_DROP_W+1)'(n_drop);
  assign rd_rec   = '{is_write: 1'b0, seq: seq_ctr, va_line: rd_fail_va[63:6]};
  assign wr_rec   = '{is_write: 1'b1, seq: seq_ctr + VTP_FAIL_SEQ_W'(rd_fail_valid), va_line: wr_fail_va[63:6]};
  vtp_fail_log_fifo2w #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we0   (!reset && (acc_rd || acc_wr)),
    .d0    (acc_rd ? rd_rec : wr_rec),
    .we1   (!reset && acc_rd && acc_wr),
    .d1    (wr_rec),
    .pop   (!reset && pop),
    .head  (head),
    .count (count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_ctr  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      seq_ctr  <= seq_ctr + VTP_FAIL_SEQ_W'(rd_fail_valid) + VTP_FAIL_SEQ_W'(wr_fail_valid);
      overflow <= (overflow && !clear_overflow) || n_drop != 2'd0;
      drop_cnt <= drop_sum[VTP_FAIL_DROP_W] ? '1 : drop_sum[VTP_FAIL_DROP_W-1:0];
    end
  end
  assign rec_valid    = count != '0;
  assign rec_va       = {head.va_line, 6'b0};
  assign rec_is_write = head.is_write;
  assign rec_seq      = head.seq;
endmodule

// File: tb/tb_vtp_fail_log.sv
// tb_vtp_fail_log: directed scenarios plus randomized traffic checked against a queue-based log model.
module tb_vtp_fail_log;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  logic clk = 1'b0;
  logic reset, rd_fail_valid, wr_fail_valid, pop, clear_overflow;
  logic [63:0] rd_fail_va, wr_fail_va, rec_va;
  logic rec_valid, rec_is_write, overflow;
  logic [15:0] rec_seq, drop_cnt;
  logic [CNT_W-1:0] count;
  always #5 clk = ~clk;

  vtp_fail_log #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rd_fail_valid(rd_fail_valid), .rd_fail_va(rd_fail_va),
    .wr_fail_valid(wr_fail_valid), .wr_fail_va(wr_fail_va),
    .pop(pop), .rec_valid(rec_valid), .rec_va(rec_va),
    .rec_is_write(rec_is_write), .rec_seq(rec_seq), .count(count),
    .overflow(overflow), .clear_overflow(clear_overflow), .drop_cnt(drop_cnt)
  );

  typedef struct { logic w; logic [15:0] s; logic [63:0] va; } rec_t;
  rec_t q[$];
  logic [15:0] m_seq, m_drop;
  logic m_ov;
  int total = 0, bad = 0;

  // Model: pop first (frees a slot), then read event, then write event, each enqueued if room.
  task automatic m_event(input logic w, input logic [63:0] va);
    rec_t r;
    r.w = w; r.s = m_seq; r.va = va & ~64'h3f;
    m_seq = m_seq + 16'd1;
    if (q.size() < DEPTH) q.push_back(r);
    else begin
      m_ov = 1'b1;
      if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
    end
  endtask

  task automatic step(input logic rd, input logic [63:0] rva, input logic wr,
                      input logic [63:0] wva, input logic p, input logic clr);
    rd_fail_valid = rd; rd_fail_va = rva; wr_fail_valid = wr; wr_fail_va = wva;
    pop = p; clear_overflow = clr;
    if (p && q.size() > 0) void'(q.pop_front());
    if (clr) begin m_ov = 1'b0; m_drop = 16'd0; end
    if (rd) m_event(1'b0, rva);
    if (wr) m_event(1'b1, wva);
    @(posedge clk); #1;
    rd_fail_valid = 0; wr_fail_valid = 0; pop = 0; clear_overflow = 0;
  endtask

  task automatic do_reset(input logic with_ev);
    reset = 1'b1; rd_fail_valid = with_ev; rd_fail_va = 64'hdead_0000; wr_fail_valid = with_ev;
    wr_fail_va = 64'hbeef_0000; pop = with_ev; clear_overflow = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; rd_fail_valid = 0; wr_fail_valid = 0; pop = 0;
    q.delete(); m_seq = 0; m_drop = 0; m_ov = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rec_valid); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    step(1, 64'h1000_0040, 0, 0, 0, 0);
    total++; if (rec_valid !== 1'b1 || rec_va !== 64'h1000_0040 || rec_is_write !== 1'b0 || rec_seq !== 16'd0 || count !== 5'd1) begin
      bad++; $display("FAIL single_head got v=%0b va=%h w=%0b s=%0d c=%0d exp v=1 va=1000_0040 w=0 s=0 c=1", rec_valid, rec_va, rec_is_write, rec_seq, count); end
    step(0, 0, 0, 0, 1, 0);
    total++; if (count !== 5'd0 || rec_valid !== 1'b0) begin bad++; $display("FAIL single_pop got c=%0d v=%0b exp c=0 v=0", count, rec_valid); end
    step(0, 0, 0, 0, 1, 0);
    total++; if (count !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL empty_pop got c=%0d o=%0b exp c=0 o=0", count, overflow); end
  endtask

  task automatic test_dual();
    do_reset(1'b0);
    step(1, 64'haaaa_0000_0000_10ff, 1, 64'hbbbb_0000_0000_2001, 0, 0);
    total++; if (count !== 5'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", count); end
    total++; if (rec_va !== 64'haaaa_0000_0000_10c0 || rec_seq !== 16'd0 || rec_is_write !== 1'b0) begin
      bad++; $display("FAIL dual_first got va=%h s=%0d w=%0b exp va=aaaa0000000010c0 s=0 w=0", rec_va, rec_seq, rec_is_write); end
    step(0, 0, 0, 0, 1, 0);
    total++; if (rec_va !== 64'hbbbb_0000_0000_2000 || rec_seq !== 16'd1 || rec_is_write !== 1'b1 || count !== 5'd1) begin
      bad++; $display("FAIL dual_second got va=%h s=%0d w=%0b c=%0d exp va=bbbb000000002000 s=1 w=1 c=1", rec_va, rec_seq, rec_is_write, count); end
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < DEPTH + 3; i++) step(1, 64'(i) << 6, 0, 0, 0, 0);
    total++; if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd3) begin
      bad++; $display("FAIL ovf_state got c=%0d o=%0b d=%0d exp c=16 o=1 d=3", count, overflow, drop_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (rec_seq !== 16'(i) || rec_va !== (64'(i) << 6)) begin
        bad++; $display("FAIL ovf_drain%0d got s=%0d va=%h exp s=%0d", i, rec_seq, rec_va, i); end
      step(0, 0, 0, 0, 1, 0);
    end
    step(1, 64'h40, 0, 0, 0, 0);
    total++; if (rec_seq !== 16'd19) begin bad++; $display("FAIL ovf_nextseq got=%0d exp=19", rec_seq); end
  endtask

  task automatic test_space_one();
    do_reset(1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1, 64'h100, 0, 0, 0, 0);
    step(1, 64'h200, 1, 64'h300, 0, 0);
    total++; if (count !== 5'd16 || drop_cnt !== 16'd1 || overflow !== 1'b1) begin
      bad++; $display("FAIL space1_drop got c=%0d d=%0d o=%0b exp c=16 d=1 o=1", count, drop_cnt, overflow); end
    step(0, 0, 0, 0, 1, 0);
    step(1, 64'h400, 1, 64'h500, 1, 0);
    total++; if (count !== 5'd16 || drop_cnt !== 16'd1 || rec_seq !== 16'd2) begin
      bad++; $display("FAIL space1_pop got c=%0d d=%0d s=%0d exp c=16 d=1 s=2", count, drop_cnt, rec_seq); end
  endtask

  task automatic test_clear_sat();
    step(1, 64'h600, 0, 0, 0, 1);
    total++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      bad++; $display("FAIL clear_drop got o=%0b d=%0d exp o=1 d=1", overflow, drop_cnt); end
    step(0, 0, 0, 0, 0, 1);
    total++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL clear_only got o=%0b d=%0d exp o=0 d=0", overflow, drop_cnt); end
    for (int i = 0; i < 32767; i++) step(1, 0, 1, 0, 0, 0);
    total++; if (drop_cnt !== 16'hfffe) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", drop_cnt); end
    step(1, 0, 1, 0, 0, 0);
    total++; if (drop_cnt !== 16'hffff) begin bad++; $display("FAIL sat_hit got=%h exp=ffff", drop_cnt); end
    step(1, 0, 1, 0, 0, 0);
    total++; if (drop_cnt !== 16'hffff || count !== 5'd16) begin
      bad++; $display("FAIL sat_hold got d=%h c=%0d exp d=ffff c=16", drop_cnt, count); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1, 64'h700, 0, 0, 0, 0);
    do_reset(1'b1);
    total++; if (count !== 5'd0 || rec_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got c=%0d v=%0b o=%0b exp c=0 v=0 o=0", count, rec_valid, overflow); end
    step(0, 0, 1, 64'h8080, 0, 0);
    total++; if (rec_seq !== 16'd0 || rec_is_write !== 1'b1 || rec_va !== 64'h8080) begin
      bad++; $display("FAIL rstmid_seq got s=%0d w=%0b va=%h exp s=0 w=1 va=8080", rec_seq, rec_is_write, rec_va); end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 45), {$urandom, $urandom}, ($urandom_range(0, 99) < 45), {$urandom, $urandom},
           ($urandom_range(0, 99) < (i % 200 < 100 ? 30 : 80)), ($urandom_range(0, 99) < 4));
      total++; if (count !== CNT_W'(q.size()) || rec_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_count cyc=%0d got c=%0d v=%0b exp c=%0d", i, count, rec_valid, q.size()); end
      total++; if (overflow !== m_ov || drop_cnt !== m_drop) begin
        bad++; $display("FAIL rnd_ovf cyc=%0d got o=%0b d=%0d exp o=%0b d=%0d", i, overflow, drop_cnt, m_ov, m_drop); end
      if (q.size() != 0) begin
        total++; if (rec_va !== q[0].va || rec_seq !== q[0].s || rec_is_write !== q[0].w) begin
          bad++; $display("FAIL rnd_head cyc=%0d got va=%h s=%0d w=%0b exp va=%h s=%0d w=%0b",
                          i, rec_va, rec_seq, rec_is_write, q[0].va, q[0].s, q[0].w); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rd_fail_valid = 0; wr_fail_valid = 0; rd_fail_va = 0; wr_fail_va = 0;
    pop = 0; clear_overflow = 0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_dual();
    test_overflow();
    test_space_one();
    test_clear_sat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
